// File: rtl/delay_line_pkg.sv
// Shared types for the delay-line receive path: FSM states, result record
// and the burst-period helper.
package delay_line_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRACK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Widest time-of-flight any instance may report; instances use the low bits.
  localparam int TOF_MAX_W = 32;

  typedef struct packed {
    logic                 hit;
    logic [TOF_MAX_W-1:0] tof;
  } result_t;

  function automatic int edge_period(input int half_period);
    return 2 * half_period;
  endfunction

endpackage

// File: rtl/echo_detector_sync_edge.sv
// sync_edge: synchroniser for the async comparator line, optional glitch filter
// (ECHO_DETECTOR_GLITCH_FILTER_EN, needs FILTER_CLKS >= 2) and rise-pulse output.
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CLKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d, level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

`ifdef ECHO_DETECTOR_GLITCH_FILTER_EN
  logic [FILTER_CLKS-2:0] hist_q;
  logic [FILTER_CLKS-1:0] win;

  assign win = {hist_q, sync_q[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= win[FILTER_CLKS-2:0];
  end

  // Level follows the line only once the whole window agrees.
  always_comb begin
    level_d = level_q;
    if (&win)       level_d = 1'b1;
    else if (~|win) level_d = 1'b0;
  end
`else
  logic unused_filter_cfg;
  assign unused_filter_cfg = (FILTER_CLKS > 0);
  assign level_d = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_d;
  end

  assign rise_o = level_d & ~level_q;

endmodule

// File: rtl/echo_detector.sv
// echo_detector: recognises a burst of PULSES correctly spaced rising edges after
// start and reports time-of-flight or timeout. Option: ECHO_DETECTOR_GLITCH_FILTER_EN.
module echo_detector
  import delay_line_pkg::*;
#(
  parameter int CLKS_PER_HALF_PERIOD = 2,
  parameter int PULSES               = 3,
  parameter int TOL                  = 1,
  parameter int TIMEOUT_CLKS         = 1023,
  parameter int TOF_WIDTH            = 10,
  parameter int SYNC_STAGES          = 2,
  parameter int FILTER_CLKS          = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 rx_in,
  output logic [TOF_WIDTH-1:0] tof,
  output logic                 hit,
  output logic                 valid,
  input  logic                 ready
);

  localparam int P       = edge_period(CLKS_PER_HALF_PERIOD);
  localparam int GAP_MAX = P + TOL + 1;
  localparam int GAP_W   = $clog2(P + TOL + 2);
  localparam int CNT_W   = $clog2(PULSES + 1);

  state_e               state_q, state_d;
  logic [TOF_WIDTH-1:0] cnt_q, cnt_d, first_q, first_d;
  logic [CNT_W-1:0]     ecnt_q, ecnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  result_t              res_q, res_d;
  logic                 rise, timeout, burst_done, in_win;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_CLKS(FILTER_CLKS)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx_in),
    .rise_o(rise)
  );

  assign timeout    = (cnt_q == TOF_WIDTH'(TIMEOUT_CLKS - 1));
  assign burst_done = (ecnt_q == CNT_W'(PULSES));
  assign in_win     = (int'(gap_q) + 1 >= P - TOL) && (int'(gap_q) + 1 <= P + TOL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    ecnt_d  = ecnt_q;
    gap_d   = gap_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ARMED;
        cnt_d   = '0;
        ecnt_d  = '0;
        gap_d   = '0;
      end
      S_ARMED: begin
        cnt_d = cnt_q + TOF_WIDTH'(1);
        if (timeout) begin
          state_d   = S_DONE;
          res_d.hit = 1'b0;
          res_d.tof = TOF_MAX_W'(TIMEOUT_CLKS - 1);
        end else if (rise) begin
          // Timestamp is the count as it stands after this edge.
          state_d = S_TRACK;
          first_d = cnt_q + TOF_WIDTH'(1);
          ecnt_d  = CNT_W'(1);
          gap_d   = '0;
        end
      end
      S_TRACK: begin
        cnt_d = cnt_q + TOF_WIDTH'(1);
        if (burst_done) begin
          state_d   = S_DONE;
          res_d.hit = 1'b1;
          res_d.tof = TOF_MAX_W'(first_q);
        end else if (timeout) begin
          state_d   = S_DONE;
          res_d.hit = 1'b0;
          res_d.tof = TOF_MAX_W'(TIMEOUT_CLKS - 1);
        end else if (rise) begin
          gap_d = '0;
          if (in_win) begin
            ecnt_d = ecnt_q + CNT_W'(1);
          end else begin
            first_d = cnt_q + TOF_WIDTH'(1);
            ecnt_d  = CNT_W'(1);
          end
        end else if (gap_q == GAP_W'(P + TOL)) begin
          state_d = S_ARMED;
          ecnt_d  = '0;
        end else if (gap_q != GAP_W'(GAP_MAX)) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: if (ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      first_q <= '0;
      ecnt_q  <= '0;
      gap_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      ecnt_q  <= ecnt_d;
      gap_q   <= gap_d;
      res_q   <= res_d;
    end
  end

  logic unused_tof_hi;
  assign unused_tof_hi = ^res_q.tof;

  assign valid = (state_q == S_DONE);
  assign hit   = res_q.hit;
  assign tof   = res_q.tof[TOF_WIDTH-1:0];

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector: table of bursts with hand-computed results,
// plus reset and backpressure sequences.
module tb_echo_detector;

`ifdef ECHO_DETECTOR_GLITCH_FILTER_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam int NONE = -100;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_in = 1'b0, ready = 1'b0;
  logic [9:0] tof;
  logic       hit, valid;
  int         checks = 0, errors = 0;

  echo_detector #(.FILTER_CLKS(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .rx_in(rx_in),
    .tof  (tof),
    .hit  (hit),
    .valid(valid),
    .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    t0, t1, t2, t3, t4;
    int    glitch;
    int    vat;
    int    hit;
    int    tof;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Pulses are high for two samples starting at edge t; a glitch is one sample.
  function automatic logic rx_level(input vec_t v, input int r);
    int ts[5];
    logic l;
    ts = '{v.t0, v.t1, v.t2, v.t3, v.t4};
    l = (r + 1 == v.glitch);
    for (int i = 0; i < 5; i++)
      if (r + 1 == ts[i] || r + 1 == ts[i] + 1) l = 1'b1;
    return l;
  endfunction

  // Pulses start (sampled at edge s = rel 0), drives rx until rel == v.vat.
  task automatic start_and_drive(input vec_t v);
    int rel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rel = 0;
    while (rel < v.vat) begin
      if (rel == v.vat - 1) chk({v.name, ".valid_early"}, valid, 0);
      rx_in = rx_level(v, rel);
      @(negedge clk);
      rel++;
    end
    rx_in = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start_and_drive(v);
    chk({v.name, ".valid"}, valid, 1);
    chk({v.name, ".hit"}, hit, v.hit);
    chk({v.name, ".tof"}, tof, v.tof);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({v.name, ".valid_drop"}, valid, 0);
  endtask

  function automatic vec_t mk(input string n, input int a, input int b, input int c,
                              input int d4, input int e, input int g, input int vat,
                              input int h, input int t);
    vec_t v;
    v.name = n; v.t0 = a; v.t1 = b; v.t2 = c; v.t3 = d4; v.t4 = e;
    v.glitch = g; v.vat = vat; v.hit = h; v.tof = t;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   seen;

    vecs.push_back(mk("clean", 100, 104, 108, NONE, NONE, NONE, 111 + D, 1, 102 + D));
    vecs.push_back(mk("spacing", 100, 104, 111, 115, 119, NONE, 122 + D, 1, 113 + D));
    vecs.push_back(mk("tol_hi", 50, 55, 60, NONE, NONE, NONE, 63 + D, 1, 52 + D));
`ifndef ECHO_DETECTOR_GLITCH_FILTER_EN
    vecs.push_back(mk("tol_lo", 50, 53, 56, NONE, NONE, NONE, 59, 1, 52));
`endif
    vecs.push_back(mk("long_gap", 40, 46, 50, 54, NONE, NONE, 57 + D, 1, 48 + D));
    vecs.push_back(mk("gap_rearm", 20, 24, 60, 64, 68, NONE, 71 + D, 1, 62 + D));
    vecs.push_back(mk("glitch", 100, 104, 108, NONE, NONE, 50, 111 + D, 1, 102 + D));
    vecs.push_back(mk("no_echo", NONE, NONE, NONE, NONE, NONE, NONE, 1023, 0, 1022));
    vecs.push_back(mk("partial", 200, 204, NONE, NONE, NONE, NONE, 1023, 0, 1022));
    vecs.push_back(mk("tie_done", 1012 - D, 1016 - D, 1020 - D, NONE, NONE, NONE, 1023, 1, 1014));
    vecs.push_back(mk("late_done", 1013 - D, 1017 - D, 1021 - D, NONE, NONE, NONE, 1023, 0, 1022));

    repeat (3) @(negedge clk);
    chk("rst.valid", valid, 0);
    chk("rst.hit", hit, 0);
    chk("rst.tof", tof, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held, start ignored while DONE.
    v = vecs[0];
    start_and_drive(v);
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      chk("bp.valid", valid, 1);
      chk("bp.hit", hit, 1);
      chk("bp.tof", tof, 102 + D);
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("bp.valid_drop", valid, 0);
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (valid) seen++;
    end
    chk("bp.no_result", seen, 0);

    // Reset in TRACK clears outputs at once; later edges give nothing.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 103; r++) begin
      rx_in = rx_level(v, r);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", valid, 0);
    chk("rst_mid.hit", hit, 0);
    chk("rst_mid.tof", tof, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int r = 104; r < 160; r++) begin
      rx_in = rx_level(mk("x", 104, 108, 112, 116, 120, NONE, 0, 0, 0), r);
      @(negedge clk);
      if (valid) seen++;
    end
    rx_in = 1'b0;
    chk("rst_mid.no_result", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
